// File: rtl/rle_symbol_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : rle_symbol_serializer
//  Purpose  : Serialises one merged 64-coefficient run-length record into
//             JPEG AC symbols (run, value), inserting ZRL for runs above 15
//             and a trailing EOB when the block ends in zeros.
//  Revision : 1.0 - initial release
// ============================================================================
module rle_symbol_serializer #(
   parameter int N     = 64,
   parameter int CNT_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_flag,
   input  logic [5:0]        in_left,
   input  logic [5:0]        in_right,
   input  logic [CNT_W-1:0]  in_size,
   input  logic [N*14-1:0]   in_array,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_run,
   output logic [7:0]        out_value,
   output logic              out_eob,
   output logic              out_last,
   output logic              busy
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] c_n_max = CNT_W'(N);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1,
      S_EOB  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [N-1:0][13:0]     arr_q, arr_d;
   logic [5:0]             right_q, right_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [6:0]             rr_q, rr_d;

   logic                   out_valid_q, out_valid_d;
   logic [3:0]             out_run_q, out_run_d;
   logic [7:0]             out_value_q, out_value_d;
   logic                   out_eob_q, out_eob_d;
   logic                   out_last_q, out_last_d;
   logic                   in_ready_q;
   logic                   busy_q;

   logic [N-1:0][13:0]     w_in_elems;
   logic [CNT_W-1:0]       w_size_eff;
   logic [IDX_W-1:0]       w_first_idx;
   logic                   w_fire;

   assign w_in_elems  = in_array;
   // Oversized counts are clamped to the record capacity.
   assign w_size_eff  = (in_size > c_n_max) ? c_n_max : in_size;
   assign w_first_idx = IDX_W'(w_size_eff - 1'b1);
   assign w_fire      = out_valid_q & out_ready;

   // Next-state: accept a record in IDLE, then walk elements from the top index down.
   always_comb begin
      state_d = state_q;
      arr_d   = arr_q;
      right_d = right_q;
      idx_d   = idx_q;
      rr_d    = rr_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               arr_d   = w_in_elems;
               right_d = in_right;
               idx_d   = w_first_idx;
               rr_d    = {1'b0, w_in_elems[w_first_idx][13:8]} + {1'b0, in_left};
               state_d = (!in_flag || (w_size_eff == '0)) ? S_EOB : S_EMIT;
            end
         end
         S_EMIT: begin
            if (w_fire) begin
               if (rr_q > 7'd15) begin
                  rr_d = rr_q - 7'd16;
               end else if (idx_q == '0) begin
                  state_d = (right_q != 6'd0) ? S_EOB : S_IDLE;
               end else begin
                  idx_d = idx_q - 1'b1;
                  rr_d  = {1'b0, arr_q[idx_d][13:8]};
               end
            end
         end
         S_EOB: begin
            if (w_fire) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Symbol decode from the next state so outputs are registered and stable under stall.
   always_comb begin
      out_valid_d = 1'b0;
      out_run_d   = 4'd0;
      out_value_d = 8'd0;
      out_eob_d   = 1'b0;
      out_last_d  = 1'b0;
      case (state_d)
         S_EMIT: begin
            out_valid_d = 1'b1;
            if (rr_d > 7'd15) begin
               out_run_d = 4'hF;
            end else begin
               out_run_d   = rr_d[3:0];
               out_value_d = arr_d[idx_d][7:0];
               out_last_d  = (idx_d == '0) && (right_d == 6'd0);
            end
         end
         S_EOB: begin
            out_valid_d = 1'b1;
            out_eob_d   = 1'b1;
            out_last_d  = 1'b1;
         end
         default: ;
      endcase
   end

   // State, datapath and output registers; reset discards any record in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         arr_q       <= '0;
         right_q     <= 6'd0;
         idx_q       <= '0;
         rr_q        <= 7'd0;
         out_valid_q <= 1'b0;
         out_run_q   <= 4'd0;
         out_value_q <= 8'd0;
         out_eob_q   <= 1'b0;
         out_last_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         arr_q       <= arr_d;
         right_q     <= right_d;
         idx_q       <= idx_d;
         rr_q        <= rr_d;
         out_valid_q <= out_valid_d;
         out_run_q   <= out_run_d;
         out_value_q <= out_value_d;
         out_eob_q   <= out_eob_d;
         out_last_q  <= out_last_d;
         in_ready_q  <= (state_d == S_IDLE);
         busy_q      <= (state_d != S_IDLE);
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out_run   = out_run_q;
   assign out_value = out_value_q;
   assign out_eob   = out_eob_q;
   assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_rle_symbol_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rle_symbol_serializer
//  Purpose  : Self-checking bench for rle_symbol_serializer. Expected symbols
//             are queued when a record is driven and compared against the
//             symbols observed on completed output handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rle_symbol_serializer;

   localparam int N     = 64;
   localparam int CNT_W = 7;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic              in_flag;
   logic [5:0]        in_left;
   logic [5:0]        in_right;
   logic [CNT_W-1:0]  in_size;
   logic [N*14-1:0]   in_array;
   logic              out_valid;
   logic              out_ready;
   logic [3:0]        out_run;
   logic [7:0]        out_value;
   logic              out_eob;
   logic              out_last;
   logic              busy;

   int n_tests = 0;
   int n_fail  = 0;

   // symbol word: {last, eob, run[3:0], value[7:0]}
   logic [13:0] exp_q[$];
   logic [13:0] obs_q[$];

   rle_symbol_serializer #(.N(N), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_flag   (in_flag),
      .in_left   (in_left),
      .in_right  (in_right),
      .in_size   (in_size),
      .in_array  (in_array),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_run   (out_run),
      .out_value (out_value),
      .out_eob   (out_eob),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture completed handshakes mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready)
         obs_q.push_back({out_last, out_eob, out_run, out_value});
   end

   function automatic logic [13:0] mk(input logic [3:0] r, input logic [7:0] v,
                                      input logic e, input logic l);
      return {l, e, r, v};
   endfunction

   // Present a record and hold it until accepted; returns #1 after the accept edge.
   task automatic send_rec(input logic flag, input logic [5:0] left, input logic [5:0] right,
                           input logic [CNT_W-1:0] size, input logic [N*14-1:0] arr,
                           output bit ok);
      bit acc;
      ok       = 1'b0;
      in_flag  = flag;
      in_left  = left;
      in_right = right;
      in_size  = size;
      in_array = arr;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (in_ready && !out_valid) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [N*14-1:0] arr_two();
      logic [N*14-1:0] a;
      a          = '0;
      a[13:0]    = {6'd2, 8'h7F};
      a[27:14]   = {6'd0, 8'h05};
      return a;
   endfunction

   function automatic logic [N*14-1:0] arr_one(input logic [7:0] v);
      logic [N*14-1:0] a;
      a       = '0;
      a[13:0] = {6'd0, v};
      return a;
   endfunction

   task automatic test_reset();
      n_tests++;
      if ({out_valid, in_ready, busy, out_eob, out_last} !== 5'b01000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got valid/ready/busy/eob/last=%b, expected 01000",
                  {out_valid, in_ready, busy, out_eob, out_last});
      end
      n_tests++;
      if ({out_run, out_value} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_sym: got run/value=%h, expected 000", {out_run, out_value});
      end
   endtask

   task automatic test_eob_only();
      bit ok;
      logic [13:0] e, o;
      exp_q.push_back(mk(4'd0, 8'h00, 1'b1, 1'b1));
      send_rec(1'b0, 6'd0, 6'd0, 7'd0, '0, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL eob_only_accept: got timeout, expected accept"); end
      n_tests++;
      if ({out_valid, in_ready, busy} !== 3'b101) begin
         n_fail++;
         $display("FAIL eob_only_latency: got valid/ready/busy=%b, expected 101", {out_valid, in_ready, busy});
      end
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         n_fail++;
         $display("FAIL eob_only_ready_back: got valid/ready/busy=%b, expected 010", {out_valid, in_ready, busy});
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_tests++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL eob_only_sym: got none, expected %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL eob_only_sym: got %h, expected %h", o, e); end
         end
      end
      n_tests++;
      if (obs_q.size() != 0) begin
         n_fail++; $display("FAIL eob_only_count: got %0d extra symbols, expected 0", obs_q.size()); obs_q.delete();
      end
   endtask

   task automatic test_two_elem();
      bit ok, ok2;
      logic [13:0] e, o;
      exp_q.push_back(mk(4'd3, 8'h05, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd2, 8'h7F, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd0, 8'h00, 1'b1, 1'b1));
      send_rec(1'b1, 6'd3, 6'd58, 7'd2, arr_two(), ok);
      wait_idle(ok2);
      n_tests++;
      if (!(ok && ok2)) begin n_fail++; $display("FAIL two_elem_done: got timeout, expected completion"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_tests++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL two_elem_sym: got none, expected %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL two_elem_sym: got %h, expected %h", o, e); end
         end
      end
      n_tests++;
      if (obs_q.size() != 0) begin
         n_fail++; $display("FAIL two_elem_count: got %0d extra symbols, expected 0", obs_q.size()); obs_q.delete();
      end
   endtask

   task automatic test_zrl_eob();
      bit ok, ok2;
      logic [13:0] e, o;
      exp_q.push_back(mk(4'hF, 8'h00, 1'b0, 1'b0));
      exp_q.push_back(mk(4'hF, 8'h00, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd8, 8'h11, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd0, 8'h00, 1'b1, 1'b1));
      send_rec(1'b1, 6'd40, 6'd23, 7'd1, arr_one(8'h11), ok);
      wait_idle(ok2);
      n_tests++;
      if (!(ok && ok2)) begin n_fail++; $display("FAIL zrl_eob_done: got timeout, expected completion"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_tests++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL zrl_eob_sym: got none, expected %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL zrl_eob_sym: got %h, expected %h", o, e); end
         end
      end
      n_tests++;
      if (obs_q.size() != 0) begin
         n_fail++; $display("FAIL zrl_eob_count: got %0d extra symbols, expected 0", obs_q.size()); obs_q.delete();
      end
   endtask

   task automatic test_zrl_last();
      bit ok, ok2;
      logic [13:0] e, o;
      exp_q.push_back(mk(4'hF, 8'h00, 1'b0, 1'b0));
      exp_q.push_back(mk(4'hF, 8'h00, 1'b0, 1'b0));
      exp_q.push_back(mk(4'hF, 8'h00, 1'b0, 1'b0));
      exp_q.push_back(mk(4'hF, 8'h01, 1'b0, 1'b1));
      send_rec(1'b1, 6'd63, 6'd0, 7'd1, arr_one(8'h01), ok);
      wait_idle(ok2);
      n_tests++;
      if (!(ok && ok2)) begin n_fail++; $display("FAIL zrl_last_done: got timeout, expected completion"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_tests++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL zrl_last_sym: got none, expected %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL zrl_last_sym: got %h, expected %h", o, e); end
         end
      end
      n_tests++;
      if (obs_q.size() != 0) begin
         n_fail++; $display("FAIL zrl_last_count: got %0d extra symbols, expected 0", obs_q.size()); obs_q.delete();
      end
   endtask

   task automatic test_backpressure();
      bit ok, ok2;
      logic [13:0] e, o;
      exp_q.push_back(mk(4'd3, 8'h05, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd2, 8'h7F, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd0, 8'h00, 1'b1, 1'b1));
      send_rec(1'b1, 6'd3, 6'd58, 7'd2, arr_two(), ok);
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_tests++;
         if ({out_valid, out_eob, out_last, out_run, out_value} !== {3'b100, 4'd2, 8'h7F}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got valid/eob/last/run/value=%b/%b/%b/%h/%h, expected 1/0/0/2/7f",
                     i, out_valid, out_eob, out_last, out_run, out_value);
         end
      end
      out_ready = 1'b1;
      wait_idle(ok2);
      n_tests++;
      if (!(ok && ok2)) begin n_fail++; $display("FAIL stall_done: got timeout, expected completion"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_tests++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL stall_sym: got none, expected %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL stall_sym: got %h, expected %h", o, e); end
         end
      end
      n_tests++;
      if (obs_q.size() != 0) begin
         n_fail++; $display("FAIL stall_count: got %0d extra symbols, expected 0", obs_q.size()); obs_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      bit ok, ok2, seen;
      logic [13:0] e, o;
      exp_q.push_back(mk(4'd3, 8'h05, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd2, 8'h7F, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd0, 8'h00, 1'b1, 1'b1));
      exp_q.push_back(mk(4'hF, 8'h00, 1'b0, 1'b0));
      exp_q.push_back(mk(4'hF, 8'h00, 1'b0, 1'b0));
      exp_q.push_back(mk(4'hF, 8'h00, 1'b0, 1'b0));
      exp_q.push_back(mk(4'hF, 8'h01, 1'b0, 1'b1));
      send_rec(1'b1, 6'd3, 6'd58, 7'd2, arr_two(), ok);
      // second record waits on the port while the first drains
      in_flag = 1'b1; in_left = 6'd63; in_right = 6'd0; in_size = 7'd1;
      in_array = arr_one(8'h01); in_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (out_valid && out_last) begin seen = 1'b1; break; end
         @(posedge clk); #1;
      end
      n_tests++;
      if (!seen) begin n_fail++; $display("FAIL b2b_first_last: got timeout, expected last symbol"); end
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++; $display("FAIL b2b_bubble: got valid/ready=%b, expected 01", {out_valid, in_ready});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_tests++;
      if ({out_valid, in_ready} !== 2'b10) begin
         n_fail++; $display("FAIL b2b_second_start: got valid/ready=%b, expected 10", {out_valid, in_ready});
      end
      wait_idle(ok2);
      n_tests++;
      if (!(ok && ok2)) begin n_fail++; $display("FAIL b2b_done: got timeout, expected completion"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_tests++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL b2b_sym: got none, expected %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL b2b_sym: got %h, expected %h", o, e); end
         end
      end
      n_tests++;
      if (obs_q.size() != 0) begin
         n_fail++; $display("FAIL b2b_count: got %0d extra symbols, expected 0", obs_q.size()); obs_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [13:0] e, o;
      exp_q.push_back(mk(4'hF, 8'h00, 1'b0, 1'b0));
      send_rec(1'b1, 6'd40, 6'd23, 7'd1, arr_one(8'h11), ok);
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, out_run, out_value} !== {1'b1, 4'hF, 8'h00}) begin
         n_fail++; $display("FAIL rst_mid_zrl2: got valid/run/value=%b/%h/%h, expected 1/f/00", out_valid, out_run, out_value);
      end
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         n_fail++; $display("FAIL rst_mid_async: got valid/ready/busy=%b, expected 010", {out_valid, in_ready, busy});
      end
      #3 rst_n = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      n_tests++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         n_fail++; $display("FAIL rst_mid_idle: got valid/ready/busy=%b, expected 010", {out_valid, in_ready, busy});
      end
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rst_mid_accept: got timeout, expected accept"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_tests++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL rst_mid_sym: got none, expected %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL rst_mid_sym: got %h, expected %h", o, e); end
         end
      end
      n_tests++;
      if (obs_q.size() != 0) begin
         n_fail++; $display("FAIL rst_mid_residual: got %0d extra symbols, expected 0", obs_q.size()); obs_q.delete();
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_flag   = 1'b0;
      in_left   = 6'd0;
      in_right  = 6'd0;
      in_size   = '0;
      in_array  = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      test_reset();
      test_eob_only();
      test_two_elem();
      test_zrl_eob();
      test_zrl_last();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_eob_only();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
